mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage, fed through the EX/MEM pipeline register.
- Performs loads and stores as multi-cycle byte sequences on a single-port, byte-wide synchronous RAM. Data is little-endian.
- Loads are sign- or zero-extended. The stage stalls the upstream pipeline while a sequence runs.
- Non-memory results pass through to the MEM/WB register with one-cycle latency.

Parameters:
- ADDR_W, 32, width of memory byte address.
- RD_W, 5, width of destination register index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_modify_flag  in  1  instruction writes rd.
- in_modify_address  in  RD_W  rd index.
- in_modify_data  in  32  ALU/link result for non-load writes.
- in_load  in  1  load instruction.
- in_save  in  1  store instruction.
- in_sl_address  in  ADDR_W  byte address of access.
- in_sl_data  in  32  store data.
- in_sl_length  in  3  access size in bytes: 1, 2 or 4.
- in_sl_signed  in  1  sign-extend load result.
- mem_din  in  8  RAM read byte; valid one cycle after its address is driven.
- mem_a  out  ADDR_W  RAM byte address.
- mem_dout  out  8  RAM write byte.
- mem_wr  out  1  RAM write strobe (1 = write).
- stall_req  out  1  upstream must hold EX/MEM contents this cycle.
- wb_flag  out  1  registered: MEM/WB writes rd.
- wb_address  out  RD_W  registered rd index.
- wb_data  out  32  registered writeback value.

Behaviour:
- States: IDLE, LOAD, STORE. Internal state:
  - cnt, 3 bits.
  - latched base address, length, signed flag and store data.
  - 32-bit load assembly register.
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, assembly register 0.
  - wb_flag=0, wb_address=0, wb_data=0.
  - mem_a=0, mem_dout=0, mem_wr=0, stall_req=0.
- In IDLE with in_valid=0: on the next edge wb_flag=0, and wb_address/wb_data are cleared to 0. mem_wr=0.
- Non-memory instruction (in_valid=1, in_load=0, in_save=0), in IDLE:
  - stall_req=0.
  - Next edge: wb_flag=in_modify_flag, wb_address=in_modify_address, wb_data=in_modify_data.
- Load, accept cycle (IDLE):
  - Drive mem_a=in_sl_address, mem_wr=0, stall_req=1.
  - Latch the operands, cnt<=1, go to LOAD.
- Load, LOAD state with cnt=c:
  - mem_din is byte c-1; store it into assembly bits [8(c-1)+7 : 8(c-1)].
  - If c<length: mem_a=base+c, cnt<=c+1, stall_req=1.
  - If c==length: stall_req=0, go to IDLE. Next edge: wb_flag=in_modify_flag, wb_address=rd.
  - wb_data for the final load: bits above 8·length are filled with the MSB of the loaded data if signed, else 0.
- Load latency: stall_req is high for exactly `length` cycles; writeback registers at the edge ending cycle length+1 after accept.
- Store, accept cycle (IDLE):
  - Drive mem_a=in_sl_address, mem_dout=in_sl_data[7:0], mem_wr=1.
  - If length==1: stall_req=0, remain IDLE.
  - Otherwise: stall_req=1, cnt<=1, go to STORE.
- Store, STORE state with cnt=c:
  - mem_a=base+c, mem_dout=data[8c+7:8c], mem_wr=1.
  - If c==length-1: stall_req=0, go to IDLE. Otherwise cnt<=c+1, stall_req=1.
- Store writeback: wb_flag=0 on completion.
- While stall_req=1, wb_flag is registered 0 (bubble into MEM/WB).
- Address arithmetic is modulo 2^ADDR_W; base+c wraps at the top of the address space.
- in_load and in_save both set: treat as load.
- in_sl_length not in {1,2,4}: treat as 4.
- Inputs are ignored outside IDLE. Upstream holds them stable while stall_req=1.
- Reset mid-sequence aborts immediately to reset values; a partially written store is not undone.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- When defined:
  - Adds output `misalign` (1 bit, registered, reset 0).
  - A halfword with address[0]≠0, or a word with address[1:0]≠0, is not performed: no mem_wr, no stall_req, wb_flag=0.
  - misalign=1 for one cycle at the next edge.
- When undefined: no misalign port; misaligned accesses are performed byte-wise as normal.

Test Plan:
- ADD passthrough: in_valid=1, flag=1, rd=5, data=0x1234 -> next edge wb_flag=1, wb_address=5, wb_data=0x1234; stall_req=0 throughout.
- LW at 0x100 with RAM bytes 0x100..0x103 = 78 56 34 12:
  - stall_req high for 4 cycles.
  - mem_a sequence 0x100..0x103.
  - wb_data=0x12345678.
- LB signed, RAM[0x20]=0x80 -> wb_data=0xFFFFFF80. LBU same address -> wb_data=0x00000080. LH signed, bytes 0xFF 0x7F -> wb_data=0x00007FFF.
- SW 0xDEADBEEF at 0x40:
  - 4 consecutive mem_wr cycles, addresses 0x40..0x43, bytes EF BE AD DE.
  - stall_req high 3 cycles, wb_flag=0.
  - SB 0xAB at 0x50 -> single write, stall_req=0.
- Wrap: LH at 0xFFFFFFFF -> mem_a 0xFFFFFFFF then 0x00000000.
- Reset: assert rst=0 during cycle 2 of a LW -> state IDLE, stall_req=0, wb_flag=0, mem_wr=0 immediately.
- (With MEM_MISALIGN_CHK_EN) LW at 0x102 -> misalign=1 for one cycle, no mem_wr, wb_flag=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
//   Loads/stores run as little-endian byte sequences on a byte-wide synchronous
//   RAM (read data arrives one cycle after its address). Loads are sign/zero
//   extended. Non-memory results pass to MEM/WB with one cycle of latency.
// Ports:
//   clk, rst (async, active low)
//   in_*        EX/MEM contents; held stable by upstream while stall_req=1
//   mem_din     RAM read byte
//   mem_a/mem_dout/mem_wr  RAM address, write byte, write strobe
//   stall_req   hold EX/MEM this cycle
//   wb_*        registered MEM/WB writeback
// Optional feature macro: MEM_MISALIGN_CHK_EN -- adds registered output
//   `misalign`; misaligned halfword/word accesses are dropped instead of run.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_modify_flag,
  input  logic [RD_W-1:0]   in_modify_address,
  input  logic [31:0]       in_modify_data,
  input  logic              in_load,
  input  logic              in_save,
  input  logic [ADDR_W-1:0] in_sl_address,
  input  logic [31:0]       in_sl_data,
  input  logic [2:0]        in_sl_length,
  input  logic              in_sl_signed,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              stall_req,
  output logic              wb_flag,
  output logic [RD_W-1:0]   wb_address,
  output logic [31:0]       wb_data
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        len_q, len_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              flag_q, flag_d;
  logic              wb_flag_q, wb_flag_d;
  logic [RD_W-1:0]   wb_address_q, wb_address_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] a_c;
  logic [7:0]        dout_c;
  logic              wr_c, stall_c;
  logic [2:0]        len_in;
  logic              misal_in;
  logic [2:0]        cnt_m1;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr_nxt;

  // Illegal sizes collapse to a word access.
  assign len_in   = (in_sl_length == 3'd1) ? 3'd1 : (in_sl_length == 3'd2) ? 3'd2 : 3'd4;
`ifdef MEM_MISALIGN_CHK_EN
  assign misal_in = ((len_in == 3'd2) && in_sl_address[0]) ||
                    ((len_in == 3'd4) && (in_sl_address[1:0] != 2'b00));
`else
  assign misal_in = 1'b0;
`endif
  assign cnt_m1   = cnt_q - 3'd1;
  assign addr_nxt = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; base_d = base_q; len_d = len_q;
    sgn_d = sgn_q; sdata_d = sdata_q; asm_d = asm_q; rd_d = rd_q; flag_d = flag_q;
    // MEM/WB gets a bubble unless something below completes this cycle.
    wb_flag_d = 1'b0; wb_address_d = '0; wb_data_d = '0; mis_d = 1'b0;
    a_c = '0; dout_c = '0; wr_c = 1'b0; stall_c = 1'b0;
    word = asm_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if ((in_load || in_save) && misal_in) begin
            mis_d = 1'b1;
          end else if (in_load) begin
            a_c = in_sl_address; stall_c = 1'b1;
            base_d = in_sl_address; len_d = len_in; sgn_d = in_sl_signed;
            rd_d = in_modify_address; flag_d = in_modify_flag;
            asm_d = '0; cnt_d = 3'd1; state_d = S_LOAD;
          end else if (in_save) begin
            a_c = in_sl_address; dout_c = in_sl_data[7:0]; wr_c = 1'b1;
            if (len_in != 3'd1) begin
              stall_c = 1'b1; base_d = in_sl_address; len_d = len_in;
              sdata_d = in_sl_data; cnt_d = 3'd1; state_d = S_STORE;
            end
          end else begin
            wb_flag_d = in_modify_flag; wb_address_d = in_modify_address;
            wb_data_d = in_modify_data;
          end
        end
      end
      S_LOAD: begin
        // mem_din now holds the byte addressed in the previous cycle.
        word[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
        asm_d = word;
        if (cnt_q < len_q) begin
          a_c = addr_nxt; stall_c = 1'b1; cnt_d = cnt_q + 3'd1;
        end else begin
          state_d = S_IDLE; cnt_d = 3'd0;
          wb_flag_d = flag_q; wb_address_d = rd_q;
          case (len_q)
            3'd1:    wb_data_d = {{24{sgn_q & word[7]}}, word[7:0]};
            3'd2:    wb_data_d = {{16{sgn_q & word[15]}}, word[15:0]};
            default: wb_data_d = word;
          endcase
        end
      end
      S_STORE: begin
        a_c = addr_nxt; dout_c = sdata_q[{cnt_q[1:0], 3'b000} +: 8]; wr_c = 1'b1;
        if (cnt_q == len_q - 3'd1) begin
          state_d = S_IDLE; cnt_d = 3'd0;
        end else begin
          stall_c = 1'b1; cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE; cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE; cnt_q <= '0; base_q <= '0; len_q <= '0; sgn_q <= 1'b0;
      sdata_q <= '0; asm_q <= '0; rd_q <= '0; flag_q <= 1'b0;
      wb_flag_q <= 1'b0; wb_address_q <= '0; wb_data_q <= '0; mis_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; base_q <= base_d; len_q <= len_d; sgn_q <= sgn_d;
      sdata_q <= sdata_d; asm_q <= asm_d; rd_q <= rd_d; flag_q <= flag_d;
      wb_flag_q <= wb_flag_d; wb_address_q <= wb_address_d; wb_data_q <= wb_data_d;
      mis_q <= mis_d;
    end
  end

  // RAM-side outputs are combinational; force them quiet while reset is held
  // so upstream contents cannot reach the RAM or the stall line.
  assign mem_a      = rst ? a_c     : '0;
  assign mem_dout   = rst ? dout_c  : '0;
  assign mem_wr     = rst & wr_c;
  assign stall_req  = rst & stall_c;
  assign wb_flag    = wb_flag_q;
  assign wb_address = wb_address_q;
  assign wb_data    = wb_data_q;
`ifdef MEM_MISALIGN_CHK_EN
  assign misalign   = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule
